// File: rtl/ps2_rx_fifo_if.sv
// rtl/ps2_rx_fifo_if.sv - PS/2 pin, pop strobe and FIFO head bundle for ps2_rx_fifo
// Signals:
//   ps2_clk, ps2_data : raw PS/2 pins (asynchronous, idle high)
//   nextdata_n        : active-low pop strobe
//   data, ready       : FIFO head scan code, valid while ready = 1
//   overflow          : sticky dropped-frame flag
//   frame_err         : one-cycle malformed-frame pulse
// master = keyboard/consumer side, slave = receiver side.
interface ps2_rx_fifo_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic       nextdata_n;
   logic [7:0] data;
   logic       ready;
   logic       overflow;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data, nextdata_n,
      input  data, ready, overflow, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data, nextdata_n,
      output data, ready, overflow, frame_err
   );
endinterface

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with scan-code FIFO
// Ports:
//   clk  : system clock, rising edge
//   clrn : asynchronous active-low reset
//   bus  : ps2_rx_fifo_if.slave (PS/2 pins in, pop strobe in, head/flags out)
// Parameters:
//   FIFO_AW : FIFO address width, depth = 2**FIFO_AW
//   TIMEOUT : idle clk cycles before a partial frame is abandoned
module ps2_rx_fifo #(
   parameter int FIFO_AW = 3,
   parameter int TIMEOUT = 50000
) (
   input  logic          clk,
   input  logic          clrn,
   ps2_rx_fifo_if.slave  bus
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int IW    = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0]      IDLE_MAX = IW'(TIMEOUT);
   localparam logic [IW-1:0]      IDLE_ONE = IW'(1);
   localparam logic [FIFO_AW:0]   PTR_ONE  = (FIFO_AW + 1)'(1);

   // Synchronisers: three stages on ps2_clk so the edge detector compares
   // two already-settled samples; two stages on ps2_data.
   logic s1, s2, s3;
   logic d1, d2;
   logic fall;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
         d1 <= 1'b1;
         d2 <= 1'b1;
      end else begin
         s1 <= bus.ps2_clk;
         s2 <= s1;
         s3 <= s2;
         d1 <= bus.ps2_data;
         d2 <= d1;
      end
   end

   assign fall = s3 & ~s2;

   // Deframer. After ten shifts sh[0] holds the start bit, sh[8:1] the data
   // byte and sh[9] the parity bit; the stop bit is still on d2 when cnt = 10.
   // The verdict is registered (done/ok/rx_byte) and acted on one clock later.
   logic [3:0]    cnt;
   logic [9:0]    sh;
   logic [IW-1:0] idle;
   logic          done;
   logic          ok;
   logic [7:0]    rx_byte;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt     <= 4'd0;
         sh      <= 10'd0;
         idle    <= '0;
         done    <= 1'b0;
         ok      <= 1'b0;
         rx_byte <= 8'd0;
      end else begin
         done <= 1'b0;
         if (fall) begin
            idle <= '0;
            if (cnt == 4'd10) begin
               cnt     <= 4'd0;
               done    <= 1'b1;
               ok      <= ~sh[0] & d2 & (^sh[9:1]);
               rx_byte <= sh[8:1];
            end else begin
               sh  <= {d2, sh[9:1]};
               cnt <= cnt + 4'd1;
            end
         end else if (cnt != 4'd0) begin
            // A stalled partial frame is dropped without raising frame_err.
            if (idle == IDLE_MAX) begin
               cnt  <= 4'd0;
               idle <= '0;
            end else begin
               idle <= idle + IDLE_ONE;
            end
         end else begin
            idle <= '0;
         end
      end
   end

   // FIFO with one extra pointer bit to tell full from empty.
   logic [FIFO_AW:0] wptr, rptr;
   logic [7:0]       mem [DEPTH];
   logic             empty, full, push, pop;
   logic             overflow_q, frame_err_q;

   assign empty = (wptr == rptr);
   assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                  (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
   // Fullness is judged before this cycle's pop, so a push into a full FIFO
   // is dropped even when a pop happens on the same edge.
   assign push  = done & ok & ~full;
   assign pop   = ~empty & ~bus.nextdata_n;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wptr        <= '0;
         rptr        <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'd0;
         end
      end else begin
         if (push) begin
            mem[wptr[FIFO_AW-1:0]] <= rx_byte;
            wptr <= wptr + PTR_ONE;
         end
         if (pop) begin
            rptr <= rptr + PTR_ONE;
         end
         frame_err_q <= done & ~ok;
         if (done & ok & full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign bus.data      = mem[rptr[FIFO_AW-1:0]];
   assign bus.ready     = ~empty;
   assign bus.overflow  = overflow_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

   logic clk = 1'b0;
   logic clrn = 1'b0;
   always #5 clk = ~clk;

   ps2_rx_fifo_if bus ();

   ps2_rx_fifo #(.FIFO_AW(3), .TIMEOUT(64)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cyc_stop = 0;
   int cyc_ready = 0;
   int cyc_err = 0;
   int ferr_cycles = 0;
   int stops_done = 0;
   logic prev_ready = 1'b0;
   logic prev_ferr = 1'b0;
   logic [7:0] model_q [$];
   logic [7:0] exp_q [$];
   logic exp_ovf = 1'b0;

   typedef struct {
      logic [7:0] code;
      bit         bad_start;
      bit         bad_par;
      bit         bad_stop;
      bit         exp_err;
   } vec_t;

   vec_t vecs [7];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_ready <= bus.ready;
      prev_ferr  <= bus.frame_err;
      if (bus.ready && !prev_ready) cyc_ready <= cyc;
      if (bus.frame_err && !prev_ferr) cyc_err <= cyc;
      if (bus.frame_err) ferr_cycles <= ferr_cycles + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      clrn = 1'b0;
      repeat (2) @(negedge clk);
      clrn = 1'b1;
      model_q.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic push_model(input logic [7:0] c);
      if (model_q.size() < 8) model_q.push_back(c);
      else exp_ovf = 1'b1;
   endtask

   // One bit every 40 clk; data changes while ps2_clk is high.
   task automatic send_frame(input logic [7:0] code, input bit bs, input bit bp,
                             input bit bst, input int nbits);
      logic [10:0] bits;
      bits[0]   = bs;
      bits[8:1] = code;
      bits[9]   = ~(^code) ^ bp;
      bits[10]  = ~bst;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.ps2_data = bits[i];
         repeat (20) @(negedge clk);
         bus.ps2_clk = 1'b0;
         if (i == 10) begin
            cyc_stop = cyc;
            stops_done++;
         end
         repeat (20) @(negedge clk);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic pulse_pop();
      @(negedge clk);
      bus.nextdata_n = 1'b0;
      @(negedge clk);
      bus.nextdata_n = 1'b1;
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] tmp;
      if (model_q.size() == 0) begin
         check({tag, " ready before empty pop"}, bus.ready, 0);
         pulse_pop();
         check({tag, " ready after empty pop"}, bus.ready, 0);
      end else begin
         check({tag, " head data"}, bus.data, model_q[0]);
         pulse_pop();
         tmp = model_q.pop_front();
         check({tag, " ready after pop"}, bus.ready, model_q.size() != 0);
      end
   endtask

   initial begin
      int e0;
      bus.ps2_clk = 1'b1;
      bus.ps2_data = 1'b1;
      bus.nextdata_n = 1'b1;
      clrn = 1'b0;

      vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{8'h32, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check("reset ready", bus.ready, 0);
      check("reset data", bus.data, 8'h00);
      check("reset overflow", bus.overflow, 0);
      check("reset frame_err", bus.frame_err, 0);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven single frames: good, bad parity, bad stop, bad start.
      for (int i = 0; i < 7; i++) begin
         e0 = ferr_cycles;
         send_frame(vecs[i].code, vecs[i].bad_start, vecs[i].bad_par, vecs[i].bad_stop, 11);
         if (!vecs[i].exp_err) push_model(vecs[i].code);
         repeat (6) @(negedge clk);
         check($sformatf("vec%0d frame_err cycles", i), ferr_cycles - e0, vecs[i].exp_err ? 1 : 0);
         check($sformatf("vec%0d ready", i), bus.ready, model_q.size() != 0);
         if (vecs[i].exp_err)
            check($sformatf("vec%0d frame_err latency", i), cyc_err - cyc_stop, 4);
         else begin
            check($sformatf("vec%0d ready latency", i), cyc_ready - cyc_stop, 4);
            pop_check($sformatf("vec%0d", i));
         end
      end

      // Overflow: nine frames, no pops.
      do_reset();
      for (int c = 1; c <= 9; c++) begin
         send_frame(8'(c), 1'b0, 1'b0, 1'b0, 11);
         push_model(8'(c));
         if (c == 8) begin
            repeat (6) @(negedge clk);
            check("ovf after 8 frames", bus.overflow, exp_ovf);
         end
      end
      repeat (6) @(negedge clk);
      check("ovf after 9 frames", bus.overflow, exp_ovf);
      check("ovf ready", bus.ready, 1);
      for (int k = 0; k < 9; k++) pop_check($sformatf("ovf pop%0d", k));
      check("ovf sticky", bus.overflow, 1);

      // Timeout: start + 4 bits of 0xFF, long idle, then 0xF0.
      do_reset();
      e0 = ferr_cycles;
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 5);
      repeat (80) @(negedge clk);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 11);
      push_model(8'hF0);
      repeat (6) @(negedge clk);
      check("timeout frame_err cycles", ferr_cycles - e0, 0);
      pop_check("timeout first");
      pop_check("timeout second");

      // Reset mid-frame with three codes queued.
      do_reset();
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 11);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 11);
      send_frame(8'h33, 1'b0, 1'b0, 1'b0, 11);
      send_frame(8'h44, 1'b0, 1'b0, 1'b0, 6);
      do_reset();
      @(negedge clk);
      check("midrst ready", bus.ready, 0);
      check("midrst data", bus.data, 8'h00);
      check("midrst overflow", bus.overflow, 0);
      check("midrst frame_err", bus.frame_err, 0);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 11);
      push_model(8'h5A);
      repeat (6) @(negedge clk);
      pop_check("midrst 5A");
      pop_check("midrst empty");

      // Wrap-around stream with prompt pops; one pop aligned with a push.
      do_reset();
      stops_done = 0;
      exp_q.delete();
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               logic [7:0] c;
               c = 8'(8'h40 + i * 11);
               exp_q.push_back(c);
               send_frame(c, 1'b0, 1'b0, 1'b0, 11);
            end
         end
         begin
            for (int i = 0; i < 20; i++) begin
               int w;
               logic [7:0] e;
               w = 0;
               while (!bus.ready && w < 2000) begin
                  @(negedge clk);
                  w++;
               end
               if (!bus.ready) begin
                  check($sformatf("wrap%0d ready timeout", i), bus.ready, 1);
                  break;
               end
               if (i == 10) begin
                  w = 0;
                  while (stops_done < 12 && w < 2000) begin
                     @(negedge clk);
                     w++;
                  end
                  while (cyc < cyc_stop + 3) @(negedge clk);
                  e = exp_q.pop_front();
                  check("wrap10 head data", bus.data, e);
                  bus.nextdata_n = 1'b0;
                  @(negedge clk);
                  bus.nextdata_n = 1'b1;
                  check("wrap concurrent ready", bus.ready, 1);
                  check("wrap concurrent data", bus.data, exp_q[0]);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("wrap%0d data", i), bus.data, e);
                  pulse_pop();
               end
            end
         end
      join
      repeat (4) @(negedge clk);
      check("wrap leftover expected", exp_q.size(), 0);
      check("wrap ready", bus.ready, 0);
      check("wrap overflow", bus.overflow, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 keyboard receiver with an 8-entry scan-code FIFO. It samples the external `ps2_clk`/`ps2_data` lines in the system clock domain and deframes 11-bit PS/2 frames. Each valid scan code is queued, and the queue head is presented to the two-digit hex display stage through a `ready`/`data` pair. The consumer acknowledges each code with an active-low pop strobe.

## Interface
Parameters:
- `FIFO_AW`, default 3: FIFO address width; depth = 2**FIFO_AW (8).
- `TIMEOUT`, default 50000: number of idle clk cycles after which a partial frame is abandoned.

Ports:
- `clk` input, 1 bit: system clock. All logic runs on its rising edge.
- `clrn` input, 1 bit: reset, asynchronous, active-low.
- `ps2_clk` input, 1 bit: raw PS/2 clock pin. Asynchronous; idles high.
- `ps2_data` input, 1 bit: raw PS/2 data pin. Asynchronous; idles high.
- `nextdata_n` input, 1 bit: pop strobe, active-low, sampled on clk.
- `data` output, 8 bits: FIFO head scan code. Valid only while `ready` = 1.
- `ready` output, 1 bit: high while the FIFO is non-empty.
- `overflow` output, 1 bit: sticky flag, set when a valid frame is dropped because the FIFO is full.
- `frame_err` output, 1 bit: one-cycle pulse on a malformed frame.

## Operation
**Synchronisers**
- `ps2_clk` goes through three flops: s1, s2, s3.
- `ps2_data` goes through two flops: d1, d2.
- All synchroniser flops reset to 1.
- Falling edge `fall` = s3 & ~s2.

**Deframer**
- Holds a 4-bit bit counter `cnt` (0..10) and a 10-bit shift register.
- On every clock with `fall` = 1: d2 is shifted in LSB-first and `cnt` increments.
- At `cnt` = 10 (stop bit), the frame is checked:
  - start bit = 0;
  - stop bit (d2) = 1;
  - XOR of the 8 data bits and the parity bit = 1 (odd parity).
- On every frame completion, `cnt` returns to 0.

**Frame outcomes**
- Valid frame, FIFO not full: data byte is written at `wptr`, and `wptr` increments.
- Valid frame, FIFO full: byte is dropped and `overflow` is set to 1. `overflow` is cleared only by `clrn`.
- Invalid frame: nothing is written and `frame_err` = 1 for exactly one cycle.

**Timeout**
- An idle counter runs while `cnt` != 0. It clears on every `fall`.
- When the counter reaches `TIMEOUT`, `cnt` is set to 0 and the partial frame is discarded silently (no `frame_err`).
- The idle counter does not run while `cnt` = 0.

**FIFO**
- Pointers `wptr` and `rptr` are each FIFO_AW+1 bits wide.
- Empty when `wptr` == `rptr`.
- Full when the pointers' MSBs differ and their low bits are equal.
- Pointers wrap naturally modulo 2**(FIFO_AW+1).
- `ready` = ~empty.
- `data` = mem[`rptr` low bits], driven combinationally from storage.

**Pop**
- When `ready` = 1 and `nextdata_n` = 0 at a rising clk edge, `rptr` increments.
- When `nextdata_n` = 0 while empty, nothing happens: no pointer moves and no flag is set.
- Holding `nextdata_n` low pops one entry per cycle.

**Simultaneous push and pop**
- Fullness is evaluated on pre-pop state. When full, the push is dropped (with `overflow` set) even if a pop occurs in the same cycle.
- When not full, push and pop complete in the same cycle and the occupancy count is unchanged.

**Reset**
- Asynchronous `clrn` = 0 clears:
  - pointers, `cnt`, shift register, idle counter;
  - all memory entries (set to 0);
  - `overflow` and `frame_err`.
- Resulting output state: `ready` = 0, `data` = 8'h00, `overflow` = 0, `frame_err` = 0.
- Reset mid-frame discards the partial frame. Reception restarts on the next start bit after `clrn` is released.

## Timing
**Latency**
- A falling edge on the `ps2_clk` pin produces `fall` on the 3rd rising clk edge after it.
- `ready` rises 1 clock after the `fall` of the stop bit.
- Total: the 4th rising edge after the stop-bit pin edge.

**Pop response**
- `ready` falls, or `data` advances, on the clock edge that samples `nextdata_n` = 0.

**Flags**
- `frame_err` is asserted in the cycle after the stop-bit `fall` and lasts one cycle.
- `overflow` is asserted in that same cycle and then stays high.

**Input constraints**
- Both pins must be stable for at least 3 clk periods around each `ps2_clk` edge. The real PS/2 rate (10–16.7 kHz) gives ample margin at any clk ≥ 1 MHz.

**Throughput**
- At most one push and one pop per cycle.

## Test plan
All scenarios use `TIMEOUT` = 64 and a PS/2 bit period of 40 clk.

- **Single frame:** send 0x1C with correct parity → `ready` = 1, `data` = 0x1C, `frame_err` = 0. Pulse `nextdata_n` low for 1 cycle → `ready` = 0 on that edge.
- **Parity error:** send 0x1C with the parity bit flipped → `frame_err` high for exactly 1 cycle, `ready` stays 0. A following valid 0x32 → `data` = 0x32.
- **Overflow:** send 0x01..0x09 with no pops → `ready` = 1 and `overflow` = 1 after the 9th frame. Eight pops return 0x01..0x08 in order, then `ready` = 0. A 9th pop changes nothing and `overflow` remains 1.
- **Timeout:** send a start bit plus 4 data bits of 0xFF, idle 80 clk, then a full frame 0xF0 → exactly one entry, 0xF0, and no `frame_err`.
- **Reset mid-frame:** pulse `clrn` low for 2 cycles after 6 bits of a frame, with 3 codes already queued → `ready` = 0, `data` = 0x00, `overflow` = 0. The next complete frame 0x5A is received correctly.
- **Wrap-around with concurrent pop:** stream 20 frames while popping each as soon as `ready` rises, with one pop landing on the same edge as a push → all 20 codes are received in order, `overflow` = 0, and the pointers wrap without loss.
